// File: rtl/dmem_line_adapter.sv
// dmem_line_adapter
//   Serves the load/store unit's word-wide dmem port from a single 256-bit
//   write-back line buffer. Hits complete in one cycle. A miss optionally
//   writes back the dirty line as four 64-bit beats, then refills the line
//   with four 64-bit beats from the burst memory port. The request then hits.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   dmem_addr_*   request byte address (bits [1:0] ignored)
//   dmem_rmask    load byte mask, nonzero = load request
//   dmem_wmask    store byte mask, nonzero = store request (wins over load)
//   dmem_wdata    lane-aligned store data
//   dmem_rdata    aligned word returned with dmem_resp (holds between responses)
//   dmem_resp     one-cycle completion pulse
//   bmem_addr     line-aligned burst address
//   bmem_read     fill request, held until bmem_ready
//   bmem_write    writeback beat valid
//   bmem_wdata    writeback beat data
//   bmem_ready    memory accepts the read request / write beat
//   bmem_rdata    fill beat data
//   bmem_rvalid   fill beat valid, beats in order 0..BEATS-1
module dmem_line_adapter #(
    parameter int BEATS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] bmem_addr,
    output logic        bmem_read,
    output logic        bmem_write,
    output logic [63:0] bmem_wdata,
    input  logic        bmem_ready,
    input  logic [63:0] bmem_rdata,
    input  logic        bmem_rvalid
);

    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RESP      = 3'd1;
    localparam logic [2:0] S_WB        = 3'd2;
    localparam logic [2:0] S_FILL_REQ  = 3'd3;
    localparam logic [2:0] S_FILL_WAIT = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             line_valid_q, line_valid_d;
    logic             line_dirty_q, line_dirty_d;
    logic [26:0]      tag_q, tag_d;
    logic [255:0]     data_q, data_d;
    logic [31:0]      rdata_q, rdata_d;

    logic        req_valid;
    logic        is_store;
    logic        hit;
    logic [2:0]  word_sel;
    logic [31:0] cur_word;
    logic [31:0] merged;
    logic        addr_lo_unused;

    assign addr_lo_unused = ^dmem_addr[1:0];

    assign req_valid = (|dmem_rmask) | (|dmem_wmask);
    assign is_store  = |dmem_wmask;
    assign hit       = line_valid_q && (tag_q == dmem_addr[31:5]);
    assign word_sel  = dmem_addr[4:2];
    assign cur_word  = data_q[{word_sel, 5'b0} +: 32];

    // Byte-lane merge of the store data into the currently selected word.
    always_comb begin
        merged = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (dmem_wmask[b]) merged[8*b +: 8] = dmem_wdata[8*b +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_valid_d = line_valid_q;
        line_dirty_d = line_dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        rdata_d      = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (hit) begin
                        state_d = S_RESP;
                        if (is_store) begin
                            data_d[{word_sel, 5'b0} +: 32] = merged;
                            line_dirty_d = 1'b1;
                            rdata_d      = merged;
                        end else begin
                            rdata_d = cur_word;
                        end
                    end else if (line_valid_q && line_dirty_q) begin
                        state_d = S_WB;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_FILL_REQ;
                    end
                end
            end
            // The held request is deliberately not looked at here; the
            // requester only changes it after seeing the response.
            S_RESP: state_d = S_IDLE;
            S_WB: begin
                if (bmem_ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        line_dirty_d = 1'b0;
                        state_d      = S_FILL_REQ;
                    end
                end
            end
            S_FILL_REQ: begin
                if (bmem_ready) begin
                    state_d      = S_FILL_WAIT;
                    line_valid_d = 1'b0;
                    cnt_d        = '0;
                end
            end
            S_FILL_WAIT: begin
                if (bmem_rvalid) begin
                    data_d[{cnt_q, 6'b0} +: 64] = bmem_rdata;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        line_valid_d = 1'b1;
                        tag_d        = dmem_addr[31:5];
                        state_d      = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            line_valid_q <= 1'b0;
            line_dirty_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_valid_q <= line_valid_d;
            line_dirty_q <= line_dirty_d;
            rdata_q      <= rdata_d;
        end
    end

    // Line contents and tag are qualified by line_valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign dmem_rdata = rdata_q;
    assign dmem_resp  = (state_q == S_RESP);
    assign bmem_read  = (state_q == S_FILL_REQ);
    assign bmem_write = (state_q == S_WB);

    always_comb begin
        bmem_addr  = '0;
        bmem_wdata = '0;
        if (state_q == S_WB) begin
            bmem_addr  = {tag_q, 5'b0};
            bmem_wdata = data_q[{cnt_q, 6'b0} +: 64];
        end else if (state_q == S_FILL_REQ) begin
            bmem_addr = {dmem_addr[31:5], 5'b0};
        end
    end

endmodule

// File: tb/tb_dmem_line_adapter.sv
module tb_dmem_line_adapter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    always #5 clk = ~clk;

    dmem_line_adapter #(.BEATS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Golden view of memory as the CPU should see it, plus backing memory.
    logic [31:0] gold [bit [31:0]];
    logic [63:0] mem  [bit [31:0]];
    logic [31:0] sb [$];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE00;
    endfunction

    function automatic logic [31:0] gword(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (gold.exists(k)) return gold[k];
        return init_word(k);
    endfunction

    function automatic logic [63:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {init_word(a + 32'd4), init_word(a)};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] wm);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (wm[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Bench-side expectation of the line buffer state.
    bit          tb_valid = 1'b0;
    bit          tb_dirty = 1'b0;
    logic [26:0] tb_tag   = '0;

    // Memory model state.
    int          wb_idx = 0, wb_beats = 0, fills = 0, fill_beat = 0, stall_left = 0;
    bit          fill_active = 1'b0, prev_stall = 1'b0;
    bit          arm_wb_stall = 1'b0, arm_fill_stall = 1'b0;
    logic [31:0] fill_addr, s_addr;
    logic [63:0] s_wdata;
    logic [1:0]  s_rw;

    initial begin : mem_model
        logic [31:0] wa;
        bmem_ready  = 1'b0;
        bmem_rvalid = 1'b0;
        bmem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                fill_active = 1'b0;
                fill_beat   = 0;
                wb_idx      = 0;
                stall_left  = 0;
                prev_stall  = 1'b0;
                bmem_ready  = 1'b0;
                bmem_rvalid = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_addr", 64'(bmem_addr), 64'(s_addr));
                    chk("stall_wdata", bmem_wdata, s_wdata);
                    chk("stall_rw", 64'({bmem_read, bmem_write}), 64'(s_rw));
                    chk("stall_resp", 64'(dmem_resp), 64'(0));
                end
                if (bmem_read || bmem_write)
                    chk("rw_excl", 64'(bmem_read & bmem_write), 64'(0));
                if (arm_wb_stall && bmem_write && wb_idx == 2) begin
                    stall_left   = 3;
                    arm_wb_stall = 1'b0;
                end
                if (arm_fill_stall && bmem_read) begin
                    stall_left     = 3;
                    arm_fill_stall = 1'b0;
                end
                bmem_ready = (stall_left == 0);
                if (stall_left > 0) stall_left--;
                prev_stall = !bmem_ready && (bmem_read || bmem_write);
                s_addr  = bmem_addr;
                s_wdata = bmem_wdata;
                s_rw    = {bmem_read, bmem_write};

                bmem_rvalid = 1'b0;
                if (fill_active) begin
                    bmem_rvalid = 1'b1;
                    bmem_rdata  = mem_rd(fill_addr + 32'(8 * fill_beat));
                    fill_beat++;
                    if (fill_beat == 4) fill_active = 1'b0;
                end
                if (bmem_write && bmem_ready) begin
                    wa = {tb_tag, 5'b0} + 32'(8 * wb_idx);
                    chk("wb_addr", 64'(bmem_addr), 64'({tb_tag, 5'b0}));
                    chk("wb_data", bmem_wdata, {gword(wa + 32'd4), gword(wa)});
                    mem[wa] = bmem_wdata;
                    wb_idx  = (wb_idx + 1) % 4;
                    wb_beats++;
                end
                if (bmem_read && bmem_ready) begin
                    chk("fill_addr", 64'(bmem_addr), 64'({dmem_addr[31:5], 5'b0}));
                    fill_addr   = {dmem_addr[31:5], 5'b0};
                    fill_active = 1'b1;
                    fill_beat   = 0;
                    fills++;
                end
            end
        end
    end

    task automatic do_req(input string tag, input logic [31:0] a, input logic [3:0] rm,
                          input logic [3:0] wm, input logic [31:0] wd, input int extra);
        logic [31:0] exp, got;
        bit          hit, dirty_miss;
        int          exp_lat, f0, w0, cyc;
        hit        = tb_valid && (a[31:5] == tb_tag);
        dirty_miss = !hit && tb_valid && tb_dirty;
        exp_lat    = hit ? 1 : ((dirty_miss ? 11 : 7) + extra);
        f0 = fills;
        w0 = wb_beats;
        if (wm != 4'h0) begin
            exp = merge(gword(a), wd, wm);
            gold[{a[31:2], 2'b00}] = exp;
        end else begin
            exp = gword(a);
        end
        sb.push_back(exp);
        dmem_addr  = a;
        dmem_rmask = rm;
        dmem_wmask = wm;
        dmem_wdata = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!dmem_resp && cyc < 300);
        if (!dmem_resp) begin
            chk({tag, "_timeout"}, 64'(dmem_resp), 64'(1));
            sb.delete();
        end else begin
            got = dmem_rdata;
            chk({tag, "_rdata"}, 64'(got), 64'(sb.pop_front()));
            chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
            chk({tag, "_fills"}, 64'(fills - f0), 64'(hit ? 0 : 1));
            chk({tag, "_wbs"}, 64'(wb_beats - w0), 64'(dirty_miss ? 4 : 0));
        end
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        @(negedge clk);
        chk({tag, "_pulse"}, 64'(dmem_resp), 64'(0));
        if (!hit) begin
            tb_valid = 1'b1;
            tb_tag   = a[31:5];
            tb_dirty = 1'b0;
        end
        if (wm != 4'h0) tb_dirty = 1'b1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] a;
        logic [3:0]  m;
        bit          st;
        rst        = 1'b1;
        dmem_addr  = '0;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
        dmem_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_rdata", 64'(dmem_rdata), 64'(0));
        chk("rst_ctl", 64'({dmem_resp, bmem_read, bmem_write}), 64'(0));
        chk("rst_baddr", 64'(bmem_addr), 64'(0));
        chk("rst_bwdata", bmem_wdata, 64'(0));
        rst = 1'b0;
        @(negedge clk);

        do_req("ld_miss", 32'h0000_1004, 4'hF, 4'h0, 32'h0, 0);
        chk("ld_miss_d0hi", 64'(dmem_rdata), 64'(init_word(32'h0000_1004)));
        do_req("ld_hit", 32'h0000_1018, 4'hF, 4'h0, 32'h0, 0);
        do_req("st_hit", 32'h0000_1008, 4'h0, 4'b0011, 32'h1234_BBBB, 0);
        do_req("ld_merged", 32'h0000_1008, 4'hF, 4'h0, 32'h0, 0);
        chk("ld_merged_val", 64'(dmem_rdata),
            64'({init_word(32'h0000_1008) & 32'hFFFF_0000} | 32'h0000_BBBB));

        arm_wb_stall   = 1'b1;
        arm_fill_stall = 1'b1;
        do_req("ld_dirty", 32'h0000_2000, 4'hF, 4'h0, 32'h0, 6);

        // Reset during the fill, after two beats have landed.
        dmem_addr  = 32'h0000_3000;
        dmem_rmask = 4'hF;
        repeat (4) @(negedge clk);
        chk("pre_rst_bus", 64'({bmem_read, bmem_write, dmem_resp}), 64'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_rdata", 64'(dmem_rdata), 64'(0));
        chk("midrst_ctl", 64'({dmem_resp, bmem_read, bmem_write}), 64'(0));
        chk("midrst_baddr", 64'(bmem_addr), 64'(0));
        chk("midrst_bwdata", bmem_wdata, 64'(0));
        dmem_rmask = 4'h0;
        tb_valid   = 1'b0;
        tb_dirty   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_req("rst_reload", 32'h0000_1000, 4'hF, 4'h0, 32'h0, 0);
        do_req("ld_stored", 32'h0000_1008, 4'hF, 4'h0, 32'h0, 0);
        do_req("st_both", 32'h0000_100C, 4'hF, 4'hF, 32'hDEAD_BEEF, 0);
        do_req("ld_both", 32'h0000_100C, 4'hF, 4'h0, 32'h0, 0);

        for (int i = 0; i < 24; i++) begin
            a  = 32'h1000 * 32'($urandom_range(1, 3)) + 32'($urandom_range(0, 7)) * 32'd4;
            m  = 4'($urandom_range(1, 15));
            st = 1'($urandom_range(0, 1));
            do_req("rand", a, st ? 4'h0 : 4'hF, st ? m : 4'h0, $urandom, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_line_adapter.md
Name: dmem_line_adapter

Overview:
- Sits directly downstream of the load/store unit's memory stage. Accepts its word-wide dmem request/response interface and serves it from a single 256-bit write-back line buffer.
- Misses are handled over a 64-bit burst memory interface: optional 4-beat writeback of the dirty line, then a 4-beat line fill.
- Gives the pipeline 1-cycle hits and a blocking, in-order miss path.

Parameters:
- BEATS, 4, 64-bit beats per line. Fixed at 4 for this revision; line = 32 bytes.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dmem_addr  in  32  request byte address; bits [1:0] ignored
- dmem_rmask  in  4  load byte mask; nonzero = load request
- dmem_wmask  in  4  store byte mask; nonzero = store request
- dmem_wdata  in  32  store data, already byte-lane aligned
- dmem_rdata  out  32  full aligned word, valid with dmem_resp
- dmem_resp  out  1  one-cycle completion pulse
- bmem_addr  out  32  line-aligned burst address
- bmem_read  out  1  fill request, held until accepted
- bmem_write  out  1  writeback beat valid
- bmem_wdata  out  64  writeback beat data
- bmem_ready  in  1  memory accepts read request / write beat this cycle
- bmem_rdata  in  64  fill beat data
- bmem_rvalid  in  1  fill beat valid; beats arrive in order 0..3

Behaviour:
- Request protocol:
  - Request valid = |dmem_rmask or |dmem_wmask.
  - Requester holds the request stable until it sees dmem_resp, then may change it the next cycle.
  - rmask and wmask both nonzero is illegal; the store takes priority.
- State held: line_valid, line_dirty, tag = addr[31:5], data[255:0]. Word select = addr[4:2]; beat i holds bytes 8i..8i+7, little-endian.
- Hit = line_valid and tag matches.
- State machine: IDLE, RESP, WB, FILL_REQ, FILL_WAIT.
- IDLE:
  - Valid request that hits → RESP. On that clock edge:
    - Load: latch the selected word into dmem_rdata.
    - Store: merge wdata bytes where wmask=1, set line_dirty, and latch the merged word into dmem_rdata.
  - Miss with line_valid & line_dirty → WB.
  - Miss otherwise → FILL_REQ.
  - No request → stay in IDLE.
- RESP:
  - dmem_resp=1 for exactly this cycle, then → IDLE.
  - The still-held request is not re-evaluated this cycle.
- WB:
  - bmem_write=1, bmem_addr={old tag,5'b0}, bmem_wdata=beat[cnt].
  - cnt advances only when bmem_ready; data is held stable while ready is low.
  - After beat 3 is accepted: clear line_dirty, → FILL_REQ.
- FILL_REQ:
  - bmem_read=1, bmem_addr={dmem_addr[31:5],5'b0}, held until bmem_ready.
  - On acceptance → FILL_WAIT; clear line_valid and cnt.
- FILL_WAIT:
  - Each bmem_rvalid writes beat[cnt] and increments cnt.
  - After beat 3: line_valid=1, tag updated, → IDLE. The request then hits, giving a RESP the following cycle.
- Latency:
  - Hit: resp at request cycle+1.
  - Clean miss: FILL_REQ cycle, then fill beats, then IDLE cycle, then RESP.
- bmem_read and bmem_write are never asserted together. dmem_resp is never asserted outside RESP.
- Outputs are 0 in states where they are not driven, except dmem_rdata, which holds its last value.
- Reset value of every output is 0: dmem_rdata, dmem_resp, bmem_addr, bmem_read, bmem_write, bmem_wdata.
- Reset also clears state to IDLE, line_valid, line_dirty and cnt.
- Reset mid-burst abandons the transaction and loses dirty data. The memory model must be reset alongside.
- rvalid outside FILL_WAIT and bmem_ready outside WB/FILL_REQ are ignored.

Test Plan:
- Reset, load addr 0x0000_1004 rmask 4'hF, line empty → bmem_read with bmem_addr 0x0000_1000. Supply beats D0..D3 → one dmem_resp pulse, dmem_rdata = D0[63:32].
- After the previous fill, load 0x0000_1018 → dmem_resp the next cycle, no bmem_read, rdata = D3[31:0].
- Store 0x0000_1008 wmask 4'b0011 wdata 0x1234_BBBB → resp after 1 cycle. Then load 0x0000_1008 → rdata = {D1[31:16],16'hBBBB}.
- With the line dirty, load 0x0000_2000 → 4 bmem_write beats at bmem_addr 0x0000_1000 carrying the merged line, then bmem_read at 0x0000_2000, then resp.
- Hold bmem_ready=0 for 3 cycles during WB beat 2 and during FILL_REQ → addr, wdata and read stay stable, cnt does not advance, no dmem_resp.
- Assert rst during FILL_WAIT after 2 beats → all outputs 0 next cycle. A later load of 0x0000_1000 issues a fresh bmem_read (no false hit).
